// File: rtl/deadlock_block_detector.sv
// Declares a kernel deadlock when a nonzero block pattern stays unchanged for STABLE_CYCLES samples.
// Define DEADLOCK_SNAPSHOT_EN to capture axis_block_sigs on block entry; otherwise block_snapshot is tied to 0.
module deadlock_block_detector #(
    parameter int AXIS_NUM      = 3,
    parameter int INST_NUM      = 1,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [AXIS_NUM-1:0] axis_block_sigs,
    input  logic [INST_NUM-1:0] inst_idle_sigs,
    input  logic [INST_NUM-1:0] inst_block_sigs,
    output logic                block,
    output logic [15:0]         block_cycles,
    output logic [AXIS_NUM-1:0] block_snapshot
);

    localparam int          SIG_W    = AXIS_NUM + INST_NUM;
    localparam logic [15:0] LAST_CNT = 16'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WATCH,
        BLOCKED
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_cnt;
    logic [15:0]        w_cnt_next;
    logic [SIG_W-1:0]   r_sig_q;
    logic               r_block;
    logic [15:0]        r_cycles;

    logic               w_cand;
    logic [SIG_W-1:0]   w_sig;
    logic               w_same;
    logic               w_sig_load;
    logic               w_enter;
    logic               w_stay;

    assign w_cand = ((|axis_block_sigs) | (|inst_block_sigs)) & ~(&inst_idle_sigs);
    assign w_sig  = {axis_block_sigs, inst_block_sigs};
    assign w_same = (w_sig == r_sig_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_sig_load = 1'b0;
        w_enter    = 1'b0;
        w_stay     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cand) begin
                    w_next     = WATCH;
                    w_cnt_next = 16'd1;
                    w_sig_load = 1'b1;
                end else begin
                    w_cnt_next = 16'd0;
                end
            end
            WATCH: begin
                if (!w_cand) begin
                    w_next     = IDLE;
                    w_cnt_next = 16'd0;
                end else if (!w_same) begin
                    // Pattern moved: the current sample starts a new run.
                    w_cnt_next = 16'd1;
                    w_sig_load = 1'b1;
                end else if (r_cnt == LAST_CNT) begin
                    w_next  = BLOCKED;
                    w_enter = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 16'd1;
                end
            end
            BLOCKED: begin
                if (w_cand && w_same) begin
                    w_stay = 1'b1;
                end else begin
                    w_next     = IDLE;
                    w_cnt_next = 16'd0;
                end
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt    <= 16'd0;
            r_sig_q  <= '0;
            r_block  <= 1'b0;
            r_cycles <= 16'd0;
        end else begin
            r_cnt   <= w_cnt_next;
            r_block <= (w_next == BLOCKED);
            if (w_sig_load) begin
                r_sig_q <= w_sig;
            end
            if (w_enter) begin
                r_cycles <= 16'd0;
            end else if (w_stay && (r_cycles != 16'hFFFF)) begin
                r_cycles <= r_cycles + 16'd1;
            end
        end
    end

`ifdef DEADLOCK_SNAPSHOT_EN
    logic [AXIS_NUM-1:0] r_snap;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_snap <= '0;
        end else if (w_enter) begin
            r_snap <= axis_block_sigs;
        end
    end

    assign block_snapshot = r_snap;
`else
    assign block_snapshot = '0;
`endif

    assign block        = r_block;
    assign block_cycles = r_cycles;

endmodule
